// File: rtl/conv2d_stream_core.sv
// conv2d_stream_core
// Streaming KxK 2D convolution engine. A weight set is loaded first, then a
// raster-order pixel stream is written into K circular line buffers. Each
// pixel that completes a valid window (stride 1 or 2) triggers a sequential
// K*K multiply-accumulate pass. The accumulator is right-shifted, saturated
// and offered downstream.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wt_valid/wt_ready   weight beat handshake, wt_data row-major
//   wt_reload           request a new weight set (frame boundary only)
//   pix_valid/pix_ready pixel beat handshake, pix_data in raster order
//   stride2             0 = stride 1, 1 = stride 2 (captured at pixel (0,0))
//   shift               right shift applied to the accumulator
//   out_valid/out_ready result handshake, out_data saturated result
//   frame_done          one-cycle pulse after the last result of a frame
module conv2d_stream_core #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int K      = 4,
  parameter int ACC_W  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [DATA_W-1:0]          wt_data,
  input  logic                       wt_reload,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [DATA_W-1:0]          pix_data,
  input  logic                       stride2,
  input  logic [$clog2(ACC_W)-1:0]   shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BUF_W = $clog2(K);
  localparam int NW    = K * K;
  localparam int WI_W  = $clog2(NW);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_KM1  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0]  ROW_KM1  = ROW_W'(K - 1);
  localparam logic [BUF_W-1:0]  BUF_LAST = BUF_W'(K - 1);
  localparam logic [WI_W-1:0]   WI_LAST  = WI_W'(NW - 1);
  localparam logic              KM1_ODD  = 1'((K - 1) % 2);
  localparam logic [DATA_W-1:0] MAX_OUT  = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    WLOAD,
    STREAM,
    MAC,
    OUT,
    FEND
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DATA_W-1:0] r_weights [NW];
  logic [DATA_W-1:0] r_lineBuf [K][IMG_W];

  logic [WI_W-1:0]   r_wtCnt;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [BUF_W-1:0]  r_bufRow;
  logic              r_stride2;
  logic [WI_W-1:0]   r_macCnt;
  logic [BUF_W-1:0]  r_macKc;
  logic [BUF_W-1:0]  r_macBuf;
  logic [COL_W-1:0]  r_macCol;
  logic [COL_W-1:0]  r_winLeft;
  logic              r_lastWin;
  logic [ACC_W-1:0]  r_acc;
  logic              r_outValid;
  logic [DATA_W-1:0] r_outData;

  logic                w_atOrigin;
  logic                w_reloadNow;
  logic                w_pixReady;
  logic                w_pixHs;
  logic                w_wtHs;
  logic                w_outHs;
  logic                w_stride;
  logic                w_rowOk;
  logic                w_colOk;
  logic                w_winValid;
  logic                w_lastPix;
  logic                w_macLast;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_accNext;
  logic [ACC_W-1:0]    w_shifted;
  logic [DATA_W-1:0]   w_sat;

  // A reload request is only honoured at the start of a frame, and it wins
  // over a pixel offered in the same cycle, so pix_ready is withheld then.
  assign w_atOrigin  = (r_row == '0) && (r_col == '0);
  assign w_reloadNow = (r_state == STREAM) && wt_reload && w_atOrigin;
  assign w_pixReady  = (r_state == STREAM) && !(wt_reload && w_atOrigin);
  assign w_pixHs     = w_pixReady && pix_valid;
  assign w_wtHs      = (r_state == WLOAD) && wt_valid;
  assign w_outHs     = r_outValid && out_ready;

  // Stride is captured on pixel (0,0); that pixel itself uses the live input.
  // With stride 2 the window offset (r-K+1) must be even, i.e. r has the same
  // parity as K-1.
  assign w_stride   = w_atOrigin ? stride2 : r_stride2;
  assign w_rowOk    = (r_row >= ROW_KM1) && (!w_stride || (r_row[0] == KM1_ODD));
  assign w_colOk    = (r_col >= COL_KM1) && (!w_stride || (r_col[0] == KM1_ODD));
  assign w_winValid = w_rowOk && w_colOk;
  assign w_lastPix  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_macLast  = (r_macCnt == WI_LAST);

  // One window tap per MAC cycle; products are unsigned and the accumulator
  // is sized so that the full K*K sum never overflows.
  assign w_prod    = (2*DATA_W)'(r_lineBuf[r_macBuf][r_macCol]) * (2*DATA_W)'(r_weights[r_macCnt]);
  assign w_accNext = r_acc + ACC_W'(w_prod);
  assign w_shifted = r_acc >> shift;
  assign w_sat     = (w_shifted > ACC_W'(MAX_OUT)) ? MAX_OUT : w_shifted[DATA_W-1:0];

  // State register for the load / stream / MAC / output / frame-end sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WLOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and the handshake outputs, which depend only on the
  // current state plus the reload qualification for pix_ready.
  always_comb begin
    w_nextState = r_state;
    wt_ready    = (r_state == WLOAD);
    pix_ready   = w_pixReady;
    out_valid   = r_outValid;
    out_data    = r_outData;
    frame_done  = (r_state == FEND);
    case (r_state)
      WLOAD: begin
        if (w_wtHs && (r_wtCnt == WI_LAST)) begin
          w_nextState = STREAM;
        end
      end
      STREAM: begin
        if (w_reloadNow) begin
          w_nextState = WLOAD;
        end else if (w_pixHs) begin
          if (w_winValid) begin
            w_nextState = MAC;
          end else if (w_lastPix) begin
            w_nextState = FEND;
          end
        end
      end
      MAC: begin
        if (w_macLast) begin
          w_nextState = OUT;
        end
      end
      OUT: begin
        if (w_outHs) begin
          w_nextState = r_lastWin ? FEND : STREAM;
        end
      end
      FEND: begin
        w_nextState = STREAM;
      end
      default: begin
        w_nextState = WLOAD;
      end
    endcase
  end

  // Datapath: weight store, line buffers, raster counters, MAC walk over the
  // window and the registered saturated result. The MAC walk starts at the
  // buffer holding the window's top row, which is the one after the buffer
  // just written (the oldest of the K rows).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        r_weights[i] <= '0;
      end
      for (int b = 0; b < K; b++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_lineBuf[b][c] <= '0;
        end
      end
      r_wtCnt    <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_bufRow   <= '0;
      r_stride2  <= 1'b0;
      r_macCnt   <= '0;
      r_macKc    <= '0;
      r_macBuf   <= '0;
      r_macCol   <= '0;
      r_winLeft  <= '0;
      r_lastWin  <= 1'b0;
      r_acc      <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      if (w_wtHs) begin
        r_weights[r_wtCnt] <= wt_data;
        r_wtCnt            <= (r_wtCnt == WI_LAST) ? '0 : r_wtCnt + 1'b1;
      end

      if (w_pixHs) begin
        r_lineBuf[r_bufRow][r_col] <= pix_data;
        if (w_atOrigin) begin
          r_stride2 <= stride2;
        end
        if (r_col == COL_LAST) begin
          r_col    <= '0;
          r_row    <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
          r_bufRow <= (r_bufRow == BUF_LAST) ? '0 : r_bufRow + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_winValid) begin
          r_acc     <= '0;
          r_macCnt  <= '0;
          r_macKc   <= '0;
          r_macBuf  <= (r_bufRow == BUF_LAST) ? '0 : r_bufRow + 1'b1;
          r_macCol  <= r_col - COL_KM1;
          r_winLeft <= r_col - COL_KM1;
          r_lastWin <= w_lastPix;
        end
      end

      if (r_state == MAC) begin
        r_acc    <= w_accNext;
        r_macCnt <= r_macCnt + 1'b1;
        if (r_macKc == BUF_LAST) begin
          r_macKc  <= '0;
          r_macCol <= r_winLeft;
          r_macBuf <= (r_macBuf == BUF_LAST) ? '0 : r_macBuf + 1'b1;
        end else begin
          r_macKc  <= r_macKc + 1'b1;
          r_macCol <= r_macCol + 1'b1;
        end
      end

      if (r_state == OUT) begin
        if (!r_outValid) begin
          r_outValid <= 1'b1;
          r_outData  <= w_sat;
        end else if (out_ready) begin
          r_outValid <= 1'b0;
        end
      end

      if (r_state == FEND) begin
        r_row    <= '0;
        r_col    <= '0;
        r_bufRow <= '0;
      end
    end
  end

endmodule
